piso_shift_out: RTL and testbench

PISO_SHIFT_OUT -- requirements
Module: piso_shift_out

---
 rtl/piso_shift_out.sv | 94 +++++++++
 tb/tb_piso_shift_out.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/piso_shift_out.sv
// Parallel-in serial-out shifter with valid/ready load and stallable output.
// Ports: clk, rst_n (sync, active-low), clear (sync abort), D/load_valid/
//        load_ready (load handshake), shift_en (advance), sdo/sdo_valid
//        (serial bit), done (end-of-frame pulse), Q (last accepted word).
module piso_shift_out #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] D,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             sdo,
    output logic             sdo_valid,
    output logic             done,
    output logic [WIDTH-1:0] Q
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic             accept;
    logic             advance;
    logic             last;
    logic             head;

    assign load_ready = (state == IDLE) & ~clear & rst_n;
    assign accept     = load_valid & load_ready;
    assign advance    = (state == SHIFT) & shift_en;
    assign last       = (cnt == LAST);

    // The register shifts toward the head, so the head is always the
    // current frame bit.
    assign head      = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign sdo_valid = (state == SHIFT);
    assign sdo       = sdo_valid & head;
    assign done      = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (advance && last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt   <= '0;
            shreg <= '0;
            Q     <= '0;
        end else if (accept) begin
            cnt   <= '0;
            shreg <= D;
            Q     <= D;
        end else if (advance) begin
            // Holding at LAST keeps cnt within 0..WIDTH-1.
            if (!last) begin
                cnt <= cnt + 1'b1;
            end
            if (MSB_FIRST) begin
                shreg <= {shreg[WIDTH-2:0], 1'b0};
            end else begin
                shreg <= {1'b0, shreg[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_piso_shift_out.sv
// Directed testbench for piso_shift_out (MSB-first and LSB-first instances
// sharing one stimulus), with hand-computed expected values.
module tb_piso_shift_out;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic [7:0] D;
    logic       load_valid;
    logic       shift_en;

    logic       load_ready, sdo, sdo_valid, done;
    logic [7:0] Q;
    logic       load_ready_l, sdo_l, sdo_valid_l, done_l;
    logic [7:0] Q_l;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    piso_shift_out #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .D(D),
        .load_valid(load_valid), .load_ready(load_ready),
        .shift_en(shift_en), .sdo(sdo), .sdo_valid(sdo_valid),
        .done(done), .Q(Q)
    );

    piso_shift_out #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .clear(clear), .D(D),
        .load_valid(load_valid), .load_ready(load_ready_l),
        .shift_en(shift_en), .sdo(sdo_l), .sdo_valid(sdo_valid_l),
        .done(done_l), .Q(Q_l)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one clock; inputs are then set and outputs sampled 1ns after.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  bits;
        logic [10:0] sbits;
        logic [7:0]  b1, b2;
        logic        vall, seen_done;

        rst_n = 1'b0; clear = 1'b0; D = '0;
        load_valid = 1'b0; shift_en = 1'b1;
        tick(); tick();
        chk("rst_load_ready", load_ready, 0);
        chk("rst_outs", {sdo, sdo_valid, done}, 0);
        chk("rst_q", Q, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_load_ready", load_ready, 1);

        // Basic MSB-first frame, 8'hA5.
        D = 8'hA5; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        bits = '0; vall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bits = {bits[6:0], sdo};
            vall &= sdo_valid & ~done;
            if (i == 3) chk("msb_q_mid", Q, 8'hA5);
            tick();
        end
        chk("msb_bits", bits, 8'hA5);
        chk("msb_valid", vall, 1);
        chk("msb_done", {done, sdo_valid, load_ready}, 3'b100);
        tick();
        chk("msb_ready_again", {load_ready, done}, 2'b10);
        chk("msb_q_hold", Q, 8'hA5);

        // LSB-first frame, 8'h01: sdo 1,0,0,0,0,0,0,0, done 9 after accept.
        D = 8'h01; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        bits = '0;
        for (int i = 0; i < 8; i++) begin
            bits = {bits[6:0], sdo_l};
            tick();
        end
        chk("lsb_bits", bits, 8'b1000_0000);
        chk("lsb_done9", done_l, 1);
        chk("lsb_q", Q_l, 8'h01);
        tick();

        // Stall: 8'hF0, three stalled edges after the 2nd bit appears.
        D = 8'hF0; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        sbits = '0; vall = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            shift_en = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
            sbits = {sbits[9:0], sdo};
            vall &= sdo_valid & ~done;
            tick();
        end
        shift_en = 1'b1;
        chk("stall_bits", sbits, 11'b111_1111_0000);
        chk("stall_valid", vall, 1);
        chk("stall_done12", done, 1);
        tick();

        // Clear at the 4th bit of 8'hFF with a simultaneous load offer.
        D = 8'hFF; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        tick(); tick(); tick();
        chk("clr_4th_bit", {sdo_valid, sdo}, 2'b11);
        clear = 1'b1; load_valid = 1'b1; D = 8'h5A;
        #1;
        chk("clr_no_ready", load_ready, 0);
        tick();
        clear = 1'b0; load_valid = 1'b0;
        chk("clr_idle", {sdo_valid, sdo, done}, 0);
        chk("clr_q", Q, 0);
        seen_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            seen_done |= done | sdo_valid;
            tick();
        end
        chk("clr_no_done", seen_done, 0);

        // Back-to-back: load_valid held, 8'h3C then 8'hC3.
        D = 8'h3C; load_valid = 1'b1;
        tick();
        D = 8'hC3;
        b1 = '0;
        for (int i = 0; i < 8; i++) begin
            b1 = {b1[6:0], sdo};
            tick();
        end
        chk("b2b_bits1", b1, 8'h3C);
        chk("b2b_done", {done, load_ready}, 2'b10);
        chk("b2b_q_first", Q, 8'h3C);
        tick();
        chk("b2b_accept_cyc", {sdo_valid, load_ready}, 2'b01);
        tick();
        load_valid = 1'b0;
        chk("b2b_q_second", Q, 8'hC3);
        b2 = '0;
        for (int i = 0; i < 8; i++) begin
            b2 = {b2[6:0], sdo};
            tick();
        end
        chk("b2b_bits2", b2, 8'hC3);
        chk("b2b_done2", done, 1);
        tick();

        // Reset for one cycle in the middle of a frame.
        D = 8'h5A; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_ready_low", load_ready, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mrst_outs", {sdo, sdo_valid, done}, 0);
        chk("mrst_q", Q, 0);
        chk("mrst_ready", load_ready, 1);
        seen_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            seen_done |= done | sdo_valid;
            tick();
        end
        chk("mrst_no_done", seen_done, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
